design1_wrapper: RTL and testbench
==================================

# design1_wrapper

Top-level wrapper for the USART XCK pin-direction subsystem of the ATmega328PB core. After reset it replays a fixed boot sequence of I/O-register writes from an internal ROM. The writes go onto an internal I/O bus, into the port data-direction registers DDRB and DDRD. The block exports the XCK pin-direction bits of USART0 and USART1, so the sequence can be checked at system level with no CPU attached.

## Interface
- Parameters: none. ROM contents and register addresses are fixed as listed under Operation.
- cp2_0  input  1  system clock; all state updates on the rising edge.
- ireset_0  input  1  asynchronous reset, active-high.
- DDR_XCKn_0  output  1  USART0 XCK direction, equal to DDRD[4] (PD4 = XCK0); 1 = output (sync master).
- DDR_XCKn_1  output  1  USART1 XCK direction, equal to DDRB[5] (PB5 = XCK1); 1 = output.

## Operation
- Internal registers:
  - DDRB at I/O address 0x04, 8 bits.
  - DDRD at I/O address 0x0A, 8 bits.
  - Writes to any other address are ignored.
- Boot ROM has 8 entries of {delay[7:0], addr[5:0], data[7:0], last}:
  - 0: delay 16, 0x0A ← 0x10
  - 1: delay 0, 0x04 ← 0x20
  - 2: delay 100, 0x04 ← 0x00
  - 3: delay 100, 0x0A ← 0x00
  - 4: delay 50, 0x04 ← 0x20
  - 5: delay 0, 0x0A ← 0x10, last = 1
  - 6–7: all zero, last = 1, never reached.
- FSM states are LOAD, WAIT, WRITE, DONE.
- LOAD:
  - Entered while reset is asserted and on the first edge after reset.
  - Loads the wait counter from entry[ptr].delay.
  - Next state is WAIT, or WRITE if the delay is 0.
- WAIT:
  - Decrements the wait counter each edge.
  - Moves to WRITE on the edge where the counter reaches 0.
- WRITE:
  - Drives one cycle of io_we = 1 with addr/data from entry[ptr]. The addressed register is updated at the end of that cycle.
  - If last = 1, next state is DONE.
  - Otherwise ptr increments. The next entry's delay is loaded directly into the counter, so no LOAD cycle is spent. Next state is WAIT, or WRITE if that delay is 0.
- DONE: terminal state. No further writes occur and the registers hold until reset.
- The outputs are direct register bits with no output logic and no extra latency.

## Timing
- Reset:
  - While ireset_0 = 1: DDRB = DDRD = 0x00, ptr = 0, state = LOAD, both outputs 0.
  - The outputs clear asynchronously, immediately on assertion of ireset_0.
- Edge numbering: edge 1 is the first rising cp2_0 edge with ireset_0 = 0.
- Write effect times. Entry i's write is visible just after edge T_i, with T_0 = 17 and T_i = T_(i-1) + delay_i + 1.

| Edge | Effect |
|---|---|
| T0 = 17 | DDR_XCKn_0 → 1 |
| T1 = 18 | DDR_XCKn_1 → 1 |
| T2 = 119 | DDR_XCKn_1 → 0 |
| T3 = 220 | DDR_XCKn_0 → 0 |
| T4 = 271 | DDR_XCKn_1 → 1 |
| T5 = 272 | DDR_XCKn_0 → 1 |

- DONE is entered after T5. From then on the outputs are constant 1/1.
- Both outputs never change on the same edge.
- Reset asserted mid-sequence: outputs go to 0 at once, and the schedule restarts from edge 1 after release.
- A zero delay gives back-to-back writes on consecutive edges.

## Test plan
- Reset held for 1 cycle, then released with period 50 ns:
  - Both outputs are 0 through edge 16.
  - DDR_XCKn_0 = 1 after edge 17.
  - DDR_XCKn_1 = 1 after edge 18.
- Continue running:
  - DDR_XCKn_1 falls after edge 119.
  - DDR_XCKn_0 falls after edge 220.
  - The outputs are 1/0 between those edges.
- Continue running:
  - DDR_XCKn_1 rises at 271 and DDR_XCKn_0 rises at 272.
  - Both stay 1 through edge 6000 with no further transitions.
- Assert ireset_0 asynchronously at edge 150 + 10 ns for 3 cycles:
  - Both outputs go 0 within the same cycle.
  - After release, the full schedule repeats relative to the new edge 1.
- Assert reset during the edge-17/18 back-to-back writes:
  - No partial update survives; both outputs are 0.
- Check the internal bus:
  - Exactly 6 io_we pulses per boot, each 1 cycle wide.
  - Addresses in order: 0x0A, 0x04, 0x04, 0x0A, 0x04, 0x0A.

Source files
------------

// File: rtl/design1_wrapper.sv
// design1_wrapper: replays a fixed boot ROM of I/O writes into DDRB/DDRD and
// exports the USART0/USART1 XCK pin-direction bits.
module design1_wrapper (
  input  logic cp2_0,
  input  logic ireset_0,
  output logic DDR_XCKn_0,
  output logic DDR_XCKn_1
);
  typedef enum logic [1:0] {LOAD, WAIT, WRITE, DONE} state_t;
  state_t state;
  logic [2:0] ptr;
  logic [7:0] cnt, ddrb, ddrd, delay, nxt_delay, io_data;
  logic [5:0] io_addr;
  logic io_we, last;
  function automatic logic [7:0] rom_delay(input logic [2:0] i);
    case (i)
      3'd0: rom_delay = 8'd16;
      3'd2: rom_delay = 8'd100;
      3'd3: rom_delay = 8'd100;
      3'd4: rom_delay = 8'd50;
      default: rom_delay = 8'd0;
    endcase
  endfunction
  function automatic logic [14:0] rom_op(input logic [2:0] i);
    case (i)
      3'd0: rom_op = {6'h0A, 8'h10, 1'b0};
      3'd1: rom_op = {6'h04, 8'h20, 1'b0};
      3'd2: rom_op = {6'h04, 8'h00, 1'b0};
      3'd3: rom_op = {6'h0A, 8'h00, 1'b0};
      3'd4: rom_op = {6'h04, 8'h20, 1'b0};
      3'd5: rom_op = {6'h0A, 8'h10, 1'b1};
      default: rom_op = {6'h00, 8'h00, 1'b1};
    endcase
  endfunction
  assign delay = rom_delay(ptr);
  assign nxt_delay = rom_delay(ptr + 3'd1);
  assign {io_addr, io_data, last} = rom_op(ptr);
  assign io_we = state == WRITE;
  assign DDR_XCKn_0 = ddrd[4];
  assign DDR_XCKn_1 = ddrb[5];
  // The LOAD edge itself counts as the first wait cycle of entry 0.
  always_ff @(posedge cp2_0 or posedge ireset_0) begin
    if (ireset_0) begin
      state <= LOAD;
      ptr <= 3'd0;
      cnt <= 8'd0;
      ddrb <= 8'h00;
      ddrd <= 8'h00;
    end else begin
      if (io_we && io_addr == 6'h04) ddrb <= io_data;
      if (io_we && io_addr == 6'h0A) ddrd <= io_data;
      case (state)
        LOAD: begin
          cnt <= delay - 8'd1;
          state <= delay > 8'd1 ? WAIT : WRITE;
        end
        WAIT: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= WRITE;
        end
        WRITE: begin
          if (last) state <= DONE;
          else begin
            ptr <= ptr + 3'd1;
            cnt <= nxt_delay;
            state <= nxt_delay == 8'd0 ? WRITE : WAIT;
          end
        end
        default: state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_design1_wrapper.sv
// tb_design1_wrapper: checks the boot write schedule against a table-driven
// model of edge times, plus async reset behaviour at fixed and random points.
module tb_design1_wrapper;
  logic clk = 1'b0, rst = 1'b1;
  logic x0, x1;
  int errors = 0, checks = 0;
  int e = 0, pulses = 0;
  logic [7:0] m_ddrb = 8'h00, m_ddrd = 8'h00;
  int dl[6] = '{16, 0, 100, 100, 50, 0};
  int ad[6] = '{10, 4, 4, 10, 4, 10};
  logic [7:0] da[6] = '{8'h10, 8'h20, 8'h00, 8'h00, 8'h20, 8'h10};
  int t[6];

  design1_wrapper dut (.cp2_0(clk), .ireset_0(rst), .DDR_XCKn_0(x0), .DDR_XCKn_1(x1));

  always #25 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d got=%h exp=%h", tag, e, got, exp);
    end
  endtask

  task automatic edge_only();
    @(posedge clk);
    if (!rst) begin
      e++;
      for (int i = 0; i < 6; i++)
        if (e == t[i]) begin
          if (ad[i] == 4) m_ddrb = da[i];
          else if (ad[i] == 10) m_ddrd = da[i];
        end
    end
  endtask

  task automatic check_cycle();
    logic exp_we;
    int idx;
    exp_we = 1'b0;
    idx = 0;
    for (int i = 0; i < 6; i++)
      if (!rst && e + 1 == t[i]) begin
        exp_we = 1'b1;
        idx = i;
      end
    chk("xck0", {7'd0, x0}, {7'd0, m_ddrd[4]});
    chk("xck1", {7'd0, x1}, {7'd0, m_ddrb[5]});
    chk("io_we", {7'd0, dut.io_we}, {7'd0, exp_we});
    if (exp_we) begin
      chk("io_addr", {2'b00, dut.io_addr}, 8'(ad[idx]));
      chk("io_data", dut.io_data, da[idx]);
    end
    if (dut.io_we === 1'b1) pulses++;
  endtask

  task automatic tick();
    edge_only();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_to(input int n);
    while (e < n && !rst) tick();
  endtask

  task automatic assert_reset(input string tag);
    rst = 1'b1;
    e = 0;
    pulses = 0;
    m_ddrb = 8'h00;
    m_ddrd = 8'h00;
    #1;
    chk({tag, "_x0"}, {7'd0, x0}, 8'd0);
    chk({tag, "_x1"}, {7'd0, x1}, 8'd0);
  endtask

  task automatic outs(input string tag, input logic a, input logic b);
    chk({tag, "_x0"}, {7'd0, x0}, {7'd0, a});
    chk({tag, "_x1"}, {7'd0, x1}, {7'd0, b});
  endtask

  initial begin
    t[0] = dl[0] + 1;
    for (int i = 1; i < 6; i++) t[i] = t[i-1] + dl[i] + 1;
    #1;
    outs("reset", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    run_to(16);   outs("e16", 1'b0, 1'b0);
    run_to(17);   outs("e17", 1'b1, 1'b0);
    run_to(18);   outs("e18", 1'b1, 1'b1);
    run_to(119);  outs("e119", 1'b1, 1'b0);
    run_to(220);  outs("e220", 1'b0, 1'b0);
    run_to(271);  outs("e271", 1'b0, 1'b1);
    run_to(272);  outs("e272", 1'b1, 1'b1);
    run_to(6000); outs("e6000", 1'b1, 1'b1);
    chk("pulses_boot1", 8'(pulses), 8'd6);
    // Fresh boot, then async reset 10 ns after edge 150.
    assert_reset("rst_a");
    repeat (2) tick();
    rst = 1'b0;
    run_to(149);
    edge_only();
    #10;
    assert_reset("rst150");
    repeat (3) tick();
    rst = 1'b0;
    run_to(17);   outs("r17", 1'b1, 1'b0);
    run_to(300);  outs("r300", 1'b1, 1'b1);
    chk("pulses_boot2", 8'(pulses), 8'd6);
    // Reset between the back-to-back writes at edges 17 and 18.
    assert_reset("rst_b");
    repeat (2) tick();
    rst = 1'b0;
    run_to(16);
    edge_only();
    #($urandom_range(2, 40));
    assert_reset("rst17");
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      run_to($urandom_range(1, 320));
      edge_only();
      #($urandom_range(1, 45));
      assert_reset("rnd");
      repeat ($urandom_range(1, 4)) tick();
      rst = 1'b0;
    end
    run_to(300);  outs("final", 1'b1, 1'b1);
    chk("pulses_final", 8'(pulses), 8'd6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
